// File: rtl/drum_pkg.sv
// Shared types and constants for the noise drum voice.
// Holds the envelope state encoding and sample/envelope widths.
package drum_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      DECAY
   } env_state_t;

   localparam int SAMPLE_W = 10;
   localparam int ENV_W    = 8;
   localparam logic [SAMPLE_W-1:0] MIDSCALE = 10'd512;

endpackage

// File: rtl/ad_envelope.sv
// Hold/decay amplitude envelope with trigger edge detect.
// A hit loads velocity, holds it, then steps down one per prescale period.
module ad_envelope
   import drum_pkg::*;
#(
   parameter int HOLD_TICKS = 64,
   parameter int PRESCALE_W = 8
) (
   input  logic                  audio_tick,
   input  logic                  reset,
   input  logic                  trigger,
   input  logic [ENV_W-1:0]      velocity,
   input  logic [PRESCALE_W-1:0] decay_rate,
   output logic [ENV_W-1:0]      env,
   output logic                  active
);

   localparam int HC_W =
      (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam logic [HC_W-1:0] HOLD_LAST =
      HC_W'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);
   localparam env_state_t HIT_STATE =
      (HOLD_TICKS > 0) ? HOLD : DECAY;

   env_state_t            state;
   logic                  trig_prev;
   logic [HC_W-1:0]       hold_cnt;
   logic [PRESCALE_W-1:0] presc;
   logic                  hit;

   assign hit = trigger & ~trig_prev;

   // Envelope FSM: a hit overrides every other transition.
   always_ff @(posedge audio_tick) begin
      if (reset) begin
         state     <= IDLE;
         trig_prev <= 1'b0;
         env       <= '0;
         hold_cnt  <= '0;
         presc     <= '0;
         active    <= 1'b0;
      end else begin
         trig_prev <= trigger;
         if (hit) begin
            env      <= velocity;
            hold_cnt <= '0;
            presc    <= '0;
            if (velocity == '0) begin
               state  <= IDLE;
               active <= 1'b0;
            end else begin
               state  <= HIT_STATE;
               active <= 1'b1;
            end
         end else begin
            unique case (state)
               IDLE: begin
                  env      <= '0;
                  hold_cnt <= '0;
                  presc    <= '0;
               end
               HOLD: begin
                  if (hold_cnt == HOLD_LAST) begin
                     state    <= DECAY;
                     hold_cnt <= '0;
                     presc    <= '0;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
               DECAY: begin
                  if (presc == decay_rate) begin
                     presc <= '0;
                     if (env <= 8'd1) begin
                        env    <= '0;
                        state  <= IDLE;
                        active <= 1'b0;
                     end else begin
                        env <= env - 1'b1;
                     end
                  end else begin
                     presc <= presc + 1'b1;
                  end
               end
               default: begin
                  state  <= IDLE;
                  env    <= '0;
                  active <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/noise_drum_voice.sv
// Noise percussion voice: envelope-scaled LFSR noise.
// Two-stage pipeline from noise/envelope to the offset-binary output.
module noise_drum_voice
   import drum_pkg::*;
#(
   parameter int HOLD_TICKS = 64,
   parameter int PRESCALE_W = 8
) (
   input  logic                  audio_tick,
   input  logic                  reset,
   input  logic                  trigger,
   input  logic [ENV_W-1:0]      velocity,
   input  logic [PRESCALE_W-1:0] decay_rate,
   input  logic [SAMPLE_W-1:0]   noise_in,
   output logic [SAMPLE_W-1:0]   voice_out,
   output logic                  active
);

   localparam int PROD_W = SAMPLE_W + ENV_W;

   logic        [ENV_W-1:0]    env;
   logic signed [SAMPLE_W-1:0] s1_s;
   logic        [ENV_W-1:0]    s1_env;
   logic signed [ENV_W:0]      env_s;
   logic signed [PROD_W-1:0]   p;
   logic signed [SAMPLE_W-1:0] q;

   ad_envelope #(
      .HOLD_TICKS (HOLD_TICKS),
      .PRESCALE_W (PRESCALE_W)
   ) u_env (
      .audio_tick (audio_tick),
      .reset      (reset),
      .trigger    (trigger),
      .velocity   (velocity),
      .decay_rate (decay_rate),
      .env        (env),
      .active     (active)
   );

   assign env_s = $signed({1'b0, s1_env});
   assign p     = PROD_W'(s1_s) * PROD_W'(env_s);
   assign q     = SAMPLE_W'(p >>> 8);

   // Stage 1 centres the noise, stage 2 registers the scaled sample.
   always_ff @(posedge audio_tick) begin
      if (reset) begin
         s1_s      <= '0;
         s1_env    <= '0;
         voice_out <= MIDSCALE;
      end else begin
         s1_s      <= {~noise_in[9], noise_in[8:0]};
         s1_env    <= env;
         voice_out <= {~q[9], q[8:0]};
      end
   end

endmodule
